wb_stage: RTL and testbench

//  Registered, parametrised writeback stage for the RV32 core; generalises the 2:1 mem/ALU writeback mux.

---
 rtl/wb_stage.sv | 158 +++++++++++++++
 tb/tb_wb_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: picks one of NSRC result sources or an aligned/extended load word and drives one register-file write.
// Latency 1 for non-loads, >=2 for loads; in_ready drops while a load waits for memory data.
module wb_stage #(
    parameter int XLEN = 32,
    parameter int NSRC = 4,
    parameter int SELW = 2,
    parameter int REGW = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_regwrite,
    input  logic [REGW-1:0]      in_rd,
    input  logic [SELW-1:0]      in_sel,
    input  logic [NSRC*XLEN-1:0] in_src,
    input  logic [2:0]           in_funct3,
    input  logic [1:0]           in_addr_lo,
    input  logic                 mem_rvalid,
    input  logic [XLEN-1:0]      mem_rdata,
    output logic                 rf_we,
    output logic [REGW-1:0]      rf_waddr,
    output logic [XLEN-1:0]      rf_wdata,
    output logic                 ld_pending,
    output logic [REGW-1:0]      ld_rd
);

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_rf_we;
    logic [REGW-1:0]   r_rf_waddr;
    logic [XLEN-1:0]   r_rf_wdata;

    logic              r_regwrite;
    logic [REGW-1:0]   r_rd;
    logic [2:0]        r_funct3;
    logic [1:0]        r_addr_lo;

    logic              w_accept;
    logic              w_is_load;
    logic              w_hold_ld;
    logic [XLEN-1:0]   w_src;
    logic [XLEN-1:0]   w_ld_ext;
    logic              w_we_nxt;
    logic [REGW-1:0]   w_waddr_nxt;
    logic [XLEN-1:0]   w_wdata_nxt;

    // Byte/half selection uses the low address bits; the word case ignores them entirely.
    function automatic logic [XLEN-1:0] load_ext(
        input logic [2:0]      f3,
        input logic [1:0]      lo,
        input logic [XLEN-1:0] w
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{lo, 3'b000} +: 8];
        h = w[{lo[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  load_ext = {{(XLEN-8){b[7]}}, b};
            3'b001:  load_ext = {{(XLEN-16){h[15]}}, h};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, b};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, h};
            default: load_ext = w;
        endcase
    endfunction

    assign in_ready   = (r_state == S_IDLE);
    assign w_accept   = in_valid & in_ready & ~flush;
    assign w_is_load  = (in_sel == SELW'(1));
    assign w_ld_ext   = load_ext(r_funct3, r_addr_lo, mem_rdata);

    assign rf_we      = r_rf_we;
    assign rf_waddr   = r_rf_waddr;
    assign rf_wdata   = r_rf_wdata;
    assign ld_pending = (r_state == S_WAIT_MEM);
    assign ld_rd      = (r_state == S_WAIT_MEM) ? r_rd : '0;

    // Out-of-range selects fall back to source 0.
    always_comb begin
        w_src = in_src[0 +: XLEN];
        for (int k = 1; k < NSRC; k++) begin
            if (int'(in_sel) == k) begin
                w_src = in_src[k*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = r_rf_waddr;
        w_wdata_nxt = r_rf_wdata;
        w_hold_ld   = 1'b0;
        if (flush) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_load) begin
                            w_state_nxt = S_WAIT_MEM;
                            w_hold_ld   = 1'b1;
                        end else begin
                            w_we_nxt    = in_regwrite & (|in_rd);
                            w_waddr_nxt = in_rd;
                            w_wdata_nxt = w_src;
                        end
                    end
                end
                S_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        w_we_nxt    = r_regwrite & (|r_rd);
                        w_waddr_nxt = r_rd;
                        w_wdata_nxt = w_ld_ext;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_rf_we    <= 1'b0;
            r_rf_waddr <= '0;
            r_rf_wdata <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rf_we    <= w_we_nxt;
            r_rf_waddr <= w_waddr_nxt;
            r_rf_wdata <= w_wdata_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regwrite <= 1'b0;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_addr_lo  <= '0;
        end else if (w_hold_ld) begin
            r_regwrite <= in_regwrite;
            r_rd       <= in_rd;
            r_funct3   <= in_funct3;
            r_addr_lo  <= in_addr_lo;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: ALU/PC+4/imm writes, load extension, x0, flush and async reset.
module tb_wb_stage;
    localparam int XLEN = 32;
    localparam int NSRC = 4;
    localparam int SELW = 2;
    localparam int REGW = 5;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic                 in_regwrite = 1'b0;
    logic [REGW-1:0]      in_rd = '0;
    logic [SELW-1:0]      in_sel = '0;
    logic [NSRC*XLEN-1:0] in_src = '0;
    logic [2:0]           in_funct3 = '0;
    logic [1:0]           in_addr_lo = '0;
    logic                 mem_rvalid = 1'b0;
    logic [XLEN-1:0]      mem_rdata = '0;
    logic                 rf_we;
    logic [REGW-1:0]      rf_waddr;
    logic [XLEN-1:0]      rf_wdata;
    logic                 ld_pending;
    logic [REGW-1:0]      ld_rd;

    int total = 0;
    int bad = 0;

    wb_stage #(.XLEN(XLEN), .NSRC(NSRC), .SELW(SELW), .REGW(REGW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_regwrite(in_regwrite),
        .in_rd(in_rd), .in_sel(in_sel), .in_src(in_src), .in_funct3(in_funct3),
        .in_addr_lo(in_addr_lo), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ld_pending(ld_pending), .ld_rd(ld_rd)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        #3;
        total++;
        if ({rf_we, rf_waddr, rf_wdata, ld_pending, ld_rd} !== '0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: we=%b waddr=%0d wdata=%h pend=%b ld_rd=%0d rdy=%b, want all 0 and rdy=1",
                     rf_we, rf_waddr, rf_wdata, ld_pending, ld_rd, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        @(negedge clk);
        in_valid = 1'b1; in_regwrite = 1'b1; in_rd = 5'd5; in_sel = 2'd0;
        in_src = {32'h0, 32'h0, 32'h0, 32'h1234_5678};
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin
            bad++;
            $display("FAIL alu_write: we=%b waddr=%0d wdata=%h, want 1 5 12345678", rf_we, rf_waddr, rf_wdata);
        end
        @(negedge clk);
        total++;
        if (rf_we !== 1'b0) begin
            bad++;
            $display("FAIL alu_pulse: we=%b, want 0", rf_we);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1; in_regwrite = 1'b1;
        in_src = {32'hFFFF_F000, 32'h0000_0104, 32'hDEAD_BEEF, 32'h1111_1111};
        in_rd = 5'd1; in_sel = 2'd2;
        @(negedge clk);
        total++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'h0000_0104 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first: we=%b waddr=%0d wdata=%h rdy=%b, want 1 1 00000104 1",
                     rf_we, rf_waddr, rf_wdata, in_ready);
        end
        in_rd = 5'd2; in_sel = 2'd3;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'hFFFF_F000 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: we=%b waddr=%0d wdata=%h rdy=%b, want 1 2 fffff000 1",
                     rf_we, rf_waddr, rf_wdata, in_ready);
        end
    endtask

    task automatic test_load();
        @(negedge clk);
        in_valid = 1'b1; in_regwrite = 1'b1; in_rd = 5'd7; in_sel = 2'd1;
        in_funct3 = 3'b000; in_addr_lo = 2'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            total++;
            if (ld_pending !== 1'b1 || in_ready !== 1'b0 || ld_rd !== 5'd7 || rf_we !== 1'b0) begin
                bad++;
                $display("FAIL load_wait%0d: pend=%b rdy=%b ld_rd=%0d we=%b, want 1 0 7 0",
                         i, ld_pending, in_ready, ld_rd, rf_we);
            end
        end
        mem_rvalid = 1'b1; mem_rdata = 32'h80FF_0000;
        @(negedge clk);
        mem_rvalid = 1'b0;
        total++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hFFFF_FF80 || ld_pending !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL load_lb: we=%b waddr=%0d wdata=%h pend=%b rdy=%b, want 1 7 ffffff80 0 1",
                     rf_we, rf_waddr, rf_wdata, ld_pending, in_ready);
        end
        @(negedge clk);
        total++;
        if (rf_we !== 1'b0) begin
            bad++;
            $display("FAIL load_pulse: we=%b, want 0", rf_we);
        end
    endtask

    task automatic test_extension();
        logic [2:0]  f3 [7] = '{3'b101, 3'b001, 3'b100, 3'b010, 3'b000, 3'b001, 3'b011};
        logic [1:0]  lo [7] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd3, 2'd2};
        logic [31:0] ex [7] = '{32'h0000_8001, 32'h0000_7F80, 32'h0000_0080, 32'h8001_7F80,
                                32'h0000_007F, 32'hFFFF_8001, 32'h8001_7F80};
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_regwrite = 1'b1; in_rd = 5'(10 + i); in_sel = 2'd1;
            in_funct3 = f3[i]; in_addr_lo = lo[i];
            @(negedge clk);
            in_valid = 1'b0;
            mem_rvalid = 1'b1; mem_rdata = 32'h8001_7F80;
            @(negedge clk);
            mem_rvalid = 1'b0;
            total++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'(10 + i) || rf_wdata !== ex[i]) begin
                bad++;
                $display("FAIL ext%0d f3=%b lo=%0d: we=%b waddr=%0d wdata=%h, want 1 %0d %h",
                         i, f3[i], lo[i], rf_we, rf_waddr, rf_wdata, 10 + i, ex[i]);
            end
        end
    endtask

    task automatic test_x0_flush();
        @(negedge clk);
        in_valid = 1'b1; in_regwrite = 1'b1; in_rd = 5'd0; in_sel = 2'd0;
        in_src = {32'h0, 32'h0, 32'h0, 32'hCAFE_0001};
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'hCAFE_0001) begin
            bad++;
            $display("FAIL x0: we=%b waddr=%0d wdata=%h, want 0 0 cafe0001", rf_we, rf_waddr, rf_wdata);
        end
        // Load, then flush coinciding with the returning data.
        in_valid = 1'b1; in_rd = 5'd9; in_sel = 2'd1; in_funct3 = 3'b010;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        @(negedge clk);
        flush = 1'b0; mem_rvalid = 1'b0;
        total++;
        if (rf_we !== 1'b0 || ld_pending !== 1'b0 || in_ready !== 1'b1 || rf_wdata !== 32'hCAFE_0001) begin
            bad++;
            $display("FAIL flush_rvalid: we=%b pend=%b rdy=%b wdata=%h, want 0 0 1 cafe0001",
                     rf_we, ld_pending, in_ready, rf_wdata);
        end
        // Flush with a valid ALU op in IDLE: not accepted.
        in_valid = 1'b1; flush = 1'b1; in_rd = 5'd3; in_sel = 2'd0;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        total++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0) begin
            bad++;
            $display("FAIL flush_idle: we=%b waddr=%0d, want 0 0", rf_we, rf_waddr);
        end
        // Stray memory data in IDLE is ignored.
        mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        mem_rvalid = 1'b0;
        total++;
        if (rf_we !== 1'b0 || rf_wdata !== 32'hCAFE_0001 || ld_pending !== 1'b0) begin
            bad++;
            $display("FAIL rvalid_idle: we=%b wdata=%h pend=%b, want 0 cafe0001 0", rf_we, rf_wdata, ld_pending);
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        in_valid = 1'b1; in_regwrite = 1'b1; in_rd = 5'd12; in_sel = 2'd1; in_funct3 = 3'b010;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (ld_pending !== 1'b1 || ld_rd !== 5'd12) begin
            bad++;
            $display("FAIL arst_pre: pend=%b ld_rd=%0d, want 1 12", ld_pending, ld_rd);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({rf_we, rf_waddr, rf_wdata, ld_pending, ld_rd} !== '0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL arst_mid: we=%b waddr=%0d wdata=%h pend=%b ld_rd=%0d rdy=%b, want all 0 and rdy=1",
                     rf_we, rf_waddr, rf_wdata, ld_pending, ld_rd, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; in_rd = 5'd4; in_sel = 2'd0;
        in_src = {32'h0, 32'h0, 32'h0, 32'h0BAD_F00D};
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h0BAD_F00D) begin
            bad++;
            $display("FAIL arst_after: we=%b waddr=%0d wdata=%h, want 1 4 0badf00d", rf_we, rf_waddr, rf_wdata);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_extension();
        test_x0_flush();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
